memory_access_stage: RTL and testbench

Pipeline memory stage (M) of the five-stage core: it receives the execute-stage results, issues load/store transactions to the data memory over a valid/ready bus, and registers everything the writeback stage consumes (ReadDataW, ALU_ResultW, PCPlus4W, RdW and the W-stage controls). It formats sub-word loads and stores. It raises StallM to the hazard unit while a transaction is outstanding, so the writeback mux always sees exactly one result per retired instruction.

---
 rtl/memory_access_stage.sv | 248 ++++++++++++++++++++++++
 tb/tb_memory_access_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
//
// Memory (M) stage of the five-stage core. It takes the execute-stage results,
// issues loads and stores to the data memory over a valid/ready bus, formats
// sub-word accesses, and registers the operands and controls that the
// writeback (W) stage uses.
//
// While a bus transaction is outstanding, StallM holds the earlier stages, and
// the W registers take in a bubble. Each retired instruction therefore
// produces exactly one writeback.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   ValidM               M holds a real instruction (0 = bubble)
//   RegWriteM            instruction writes rd
//   ResultSrcM           1 = load, 0 = ALU result
//   MemWriteM            store
//   funct3M              access size / sign
//   RdM                  destination register
//   ALU_ResultM          effective address or ALU result
//   WriteDataM           store data (rs2)
//   PCPlus4M             PC+4
//   mem_req/mem_we       bus request valid / write enable
//   mem_addr             word-aligned byte address
//   mem_wdata/mem_wstrb  lane-replicated store data / byte enables
//   mem_ready/mem_rdata  transaction complete / read word
//   StallM               hold the F/D/E/M stages
//   RegWriteW, ResultSrcW, RdW, ALU_ResultW, ReadDataW, PCPlus4W, MisalignW
//                        registered writeback operands and controls
// -----------------------------------------------------------------------------
module memory_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic              ResultSrcM,
  input  logic              MemWriteM,
  input  logic [2:0]        funct3M,
  input  logic [4:0]        RdM,
  input  logic [31:0]       ALU_ResultM,
  input  logic [31:0]       WriteDataM,
  input  logic [31:0]       PCPlus4M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              StallM,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [4:0]        RdW,
  output logic [31:0]       ALU_ResultW,
  output logic [31:0]       ReadDataW,
  output logic [31:0]       PCPlus4W,
  output logic              MisalignW
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_nxt;

  // Decode of the instruction currently in M
  logic              mem_op;
  logic              size_b, size_h, size_w;
  logic              misaligned;
  logic              aligned_op;
  logic [1:0]        off;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;

  // Bus fields held while waiting for mem_ready
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;
  logic [3:0]        cap_wstrb;
  logic              cap_we;
  logic [2:0]        cap_f3;
  logic [1:0]        cap_off;

  logic              capture;
  logic              done;

  // Load formatting
  logic [2:0]        sel_f3;
  logic [1:0]        sel_off;
  logic              sel_we;
  logic [31:0]       shifted;
  logic [31:0]       load_data;
  logic [31:0]       read_data_nxt;

  // ---------------------------------------------------------------------------
  // Access decode. Loads have unsigned byte and half variants (100 and 101).
  // For a store those codes are not valid, so they fall through to a word
  // access together with every other unlisted funct3.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so that no path can leave it unassigned and infer a latch.
    mem_op     = ValidM & (MemWriteM | ResultSrcM);
    off        = ALU_ResultM[1:0];
    size_b     = (funct3M == 3'b000) | (~MemWriteM & (funct3M == 3'b100));
    size_h     = (funct3M == 3'b001) | (~MemWriteM & (funct3M == 3'b101));
    size_w     = ~size_b & ~size_h;
    misaligned = mem_op & ((size_h & off[0]) | (size_w & (off != 2'b00)));
    aligned_op = mem_op & ~misaligned;
    m_addr     = {ALU_ResultM[ADDR_W-1:2], 2'b00};
  end

  // Store lane placement: the data is replicated across all lanes, and the
  // strobes select the lanes that the offset addresses.
  always_comb begin
    m_wstrb = 4'b0000;
    m_wdata = WriteDataM;
    if (MemWriteM) begin
      if (size_b) begin
        m_wstrb = 4'b0001 << off;
        m_wdata = {4{WriteDataM[7:0]}};
      end else if (size_h) begin
        m_wstrb = 4'b0011 << off;
        m_wdata = {2{WriteDataM[15:0]}};
      end else begin
        m_wstrb = 4'b1111;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments, so every
    // register in the design samples its pre-edge inputs.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    StallM    = 1'b0;
    done      = 1'b0;
    capture   = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (aligned_op) begin
            mem_req   = 1'b1;
            mem_we    = MemWriteM;
            mem_addr  = m_addr;
            mem_wdata = m_wdata;
            mem_wstrb = m_wstrb;
            if (mem_ready) begin
              done = 1'b1;
            end else begin
              StallM    = 1'b1;
              capture   = 1'b1;
              state_nxt = WAIT;
            end
          end
        end
        WAIT: begin
          mem_req   = 1'b1;
          mem_we    = cap_we;
          mem_addr  = cap_addr;
          mem_wdata = cap_wdata;
          mem_wstrb = cap_wstrb;
          if (mem_ready) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            StallM = 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: the capture registers are pure datapath. They are loaded before
  // they are read and are qualified by the FSM state, so they need no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      cap_addr  <= m_addr;
      cap_wdata <= m_wdata;
      cap_wstrb <= m_wstrb;
      cap_we    <= MemWriteM;
      cap_f3    <= funct3M;
      cap_off   <= off;
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction. When the access completes from WAIT, the captured size
  // and offset describe the word that is returning.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_f3    = (state == WAIT) ? cap_f3  : funct3M;
    sel_off   = (state == WAIT) ? cap_off : off;
    sel_we    = (state == WAIT) ? cap_we  : MemWriteM;
    shifted   = mem_rdata >> {sel_off, 3'b000};
    load_data = mem_rdata;
    case (sel_f3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
    // Only a completed load carries read data; everything else writes back 0
    read_data_nxt = (done & ~sel_we) ? load_data : 32'd0;
  end

  // ---------------------------------------------------------------------------
  // W registers. While the stage is stalled, the earlier stages hold the
  // M inputs, and W receives a bubble so that nothing is written back twice.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      MisalignW   <= 1'b0;
      RdW         <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= '0;
    end else if (StallM) begin
      RegWriteW <= 1'b0;
      MisalignW <= 1'b0;
    end else begin
      RegWriteW   <= RegWriteM & ValidM & ~misaligned;
      ResultSrcW  <= ResultSrcM & ValidM;
      MisalignW   <= misaligned;
      RdW         <= RdM;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= read_data_nxt;
      PCPlus4W    <= PCPlus4M;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_access_stage
//
// Drives instructions into the M stage and holds them while StallM is high,
// as the pipeline would. A behavioural memory responder adds a chosen number
// of wait cycles. Bus fields and stall are compared on every cycle; W outputs
// are compared after each edge against a model built from access sizes,
// lane arithmetic and sign-extension rules.
// -----------------------------------------------------------------------------
module tb_memory_access_stage;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              ValidM, RegWriteM, ResultSrcM, MemWriteM;
  logic [2:0]        funct3M;
  logic [4:0]        RdM;
  logic [31:0]       ALU_ResultM, WriteDataM, PCPlus4M;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic              StallM, RegWriteW, ResultSrcW, MisalignW;
  logic [4:0]        RdW;
  logic [31:0]       ALU_ResultW, ReadDataW, PCPlus4W;

  int total = 0;
  int bad   = 0;

  // Last observed bus fields and stall count, for the hand-computed checks
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_wstrb;
  int          stall_cnt;

  typedef struct {
    bit        valid, regwrite, load, store;
    bit [2:0]  f3;
    bit [4:0]  rd;
    bit [31:0] alu, wd, pc4, rdata;
    int        waits;
  } instr_t;

  memory_access_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .funct3M(funct3M), .RdM(RdM),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RdW(RdW), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W), .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int acc_size(bit [2:0] f3, bit store);
    if (f3 == 3'b000 || (!store && f3 == 3'b100)) return 1;
    if (f3 == 3'b001 || (!store && f3 == 3'b101)) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_strb(int sz, int boff);
    return 4'(((1 << sz) - 1) << boff);
  endfunction

  function automatic logic [31:0] model_wdata(int sz, logic [31:0] wd);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(bit [2:0] f3, int boff, logic [31:0] word);
    int               sz   = acc_size(f3, 1'b0);
    longint unsigned  mask = (64'd1 << (8 * sz)) - 1;
    longint unsigned  v    = (64'(word) >> (8 * boff)) & mask;
    bit               sgn  = (sz < 4) && !f3[2];
    if (sgn && v[8*sz-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic instr_t mk(bit valid, bit rw, bit ld, bit st, bit [2:0] f3,
                                bit [4:0] rd, bit [31:0] alu, bit [31:0] wd,
                                int waits, bit [31:0] rdata);
    instr_t t;
    t.valid = valid; t.regwrite = rw; t.load = ld; t.store = st; t.f3 = f3;
    t.rd = rd; t.alu = alu; t.wd = wd; t.pc4 = $urandom; t.waits = waits;
    t.rdata = rdata;
    return t;
  endfunction

  // Presents one instruction, services the bus, and checks every cycle until
  // it retires.
  task automatic run(instr_t in);
    bit          memop  = in.valid && (in.load || in.store);
    int          sz     = acc_size(in.f3, in.store);
    bit          mis    = memop && ((in.alu % sz) != 0);
    bit          active = memop && !mis;
    int          n      = active ? in.waits : 0;
    int          boff   = int'(in.alu[1:0]);
    logic [31:0] final_rdata = '0;
    stall_cnt = 0;
    @(negedge clk);
    ValidM = in.valid; RegWriteM = in.regwrite; ResultSrcM = in.load;
    MemWriteM = in.store; funct3M = in.f3; RdM = in.rd;
    ALU_ResultM = in.alu; WriteDataM = in.wd; PCPlus4M = in.pc4;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) @(negedge clk);
      // With no request outstanding, mem_ready toggles randomly and must be ignored
      mem_ready = active ? (k == n) : 1'($urandom_range(0, 1));
      mem_rdata = (k == n) ? in.rdata : $urandom;
      if (k == n) final_rdata = mem_rdata;
      #1;
      check("mem_req", mem_req, active);
      check("stallm", StallM, active && (k < n));
      if (StallM) stall_cnt++;
      if (active) begin
        check("mem_addr", mem_addr, {in.alu[31:2], 2'b00});
        check("mem_we", mem_we, in.store);
        check("mem_wstrb", mem_wstrb, in.store ? model_strb(sz, boff) : 4'b0000);
        if (in.store) check("mem_wdata", mem_wdata, model_wdata(sz, in.wd));
        last_addr = mem_addr; last_wdata = mem_wdata; last_wstrb = mem_wstrb;
      end
      @(posedge clk); #1;
      if (k < n) begin
        check("bubble_regwrite", RegWriteW, 1'b0);
        check("bubble_misalign", MisalignW, 1'b0);
      end
    end
    check("regwritew", RegWriteW, in.valid && in.regwrite && !mis);
    check("misalignw", MisalignW, mis);
    if (in.valid && !mis) begin
      check("rdw", RdW, in.rd);
      check("resultsrcw", ResultSrcW, in.load);
      check("alu_resultw", ALU_ResultW, in.alu);
      check("pcplus4w", PCPlus4W, in.pc4);
      check("readdataw", ReadDataW, (active && in.load) ? model_load(in.f3, boff, final_rdata) : 32'd0);
    end
  endtask

  initial begin
    instr_t t;
    rst = 1'b1;
    ValidM = 1'b1; RegWriteM = 1'b1; ResultSrcM = 1'b1; MemWriteM = 1'b0;
    funct3M = 3'b010; RdM = 5'd1; ALU_ResultM = 32'h40; WriteDataM = '0;
    PCPlus4M = 32'h4; mem_ready = 1'b0; mem_rdata = '0;

    // Reset: an aligned load is presented but must not be requested
    @(negedge clk); #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_stallm", StallM, 1'b0);
    @(posedge clk); #1;
    check("rst_regwritew", RegWriteW, 1'b0);
    check("rst_resultsrcw", ResultSrcW, 1'b0);
    check("rst_misalignw", MisalignW, 1'b0);
    check("rst_rdw", RdW, 5'd0);
    check("rst_alu_resultw", ALU_ResultW, 32'd0);
    check("rst_readdataw", ReadDataW, 32'd0);
    check("rst_pcplus4w", PCPlus4W, 32'd0);
    @(negedge clk);
    rst = 1'b0; ValidM = 1'b0;

    // ADD, rd=3, result 5
    run(mk(1, 1, 0, 0, 3'b000, 5'd3, 32'h5, 32'h0, 0, 32'h0));
    check("add_lit_alu", ALU_ResultW, 32'h0000_0005);
    check("add_lit_rd", RdW, 5'd3);

    // LB / LBU at 0x103, zero-wait
    run(mk(1, 1, 1, 0, 3'b000, 5'd4, 32'h103, 32'h0, 0, 32'h8000_0000));
    check("lb_lit", ReadDataW, 32'hFFFF_FF80);
    run(mk(1, 1, 1, 0, 3'b100, 5'd4, 32'h103, 32'h0, 0, 32'h8000_0000));
    check("lbu_lit", ReadDataW, 32'h0000_0080);

    // SH at 0x202, three wait cycles
    run(mk(1, 0, 0, 1, 3'b001, 5'd0, 32'h202, 32'hABCD_1234, 3, 32'h0));
    check("sh_lit_stalls", stall_cnt, 3);
    check("sh_lit_addr", last_addr, 32'h200);
    check("sh_lit_wstrb", last_wstrb, 4'b1100);
    check("sh_lit_wdata", last_wdata, 32'h1234_1234);

    // Misaligned LW at 0x006
    run(mk(1, 1, 1, 0, 3'b010, 5'd5, 32'h6, 32'h0, 2, 32'h0));
    check("lw_mis_lit", MisalignW, 1'b1);

    // Back-to-back LWs, one wait cycle each
    run(mk(1, 1, 1, 0, 3'b010, 5'd6, 32'h10, 32'h0, 1, 32'h1111_2222));
    check("lw1_lit", ReadDataW, 32'h1111_2222);
    run(mk(1, 1, 1, 0, 3'b010, 5'd7, 32'h14, 32'h0, 1, 32'h3333_4444));
    check("lw2_lit", ReadDataW, 32'h3333_4444);

    // Reset while waiting on LW at 0x40
    @(negedge clk);
    ValidM = 1'b1; RegWriteM = 1'b1; ResultSrcM = 1'b1; MemWriteM = 1'b0;
    funct3M = 3'b010; RdM = 5'd9; ALU_ResultM = 32'h40; PCPlus4M = 32'h88;
    mem_ready = 1'b0;
    #1;
    check("rstw_req_before", mem_req, 1'b1);
    check("rstw_stall_before", StallM, 1'b1);
    @(posedge clk); #1;
    check("rstw_bubble", RegWriteW, 1'b0);
    @(negedge clk);
    rst = 1'b1; #1;
    check("rstw_req_during", mem_req, 1'b0);
    check("rstw_stall_during", StallM, 1'b0);
    @(posedge clk); #1;
    check("rstw_regwritew", RegWriteW, 1'b0);
    check("rstw_resultsrcw", ResultSrcW, 1'b0);
    check("rstw_misalignw", MisalignW, 1'b0);
    check("rstw_rdw", RdW, 5'd0);
    check("rstw_alu_resultw", ALU_ResultW, 32'd0);
    check("rstw_readdataw", ReadDataW, 32'd0);
    check("rstw_pcplus4w", PCPlus4W, 32'd0);
    @(negedge clk);
    rst = 1'b0; ValidM = 1'b0; mem_ready = 1'b1; #1;
    // A bubble in IDLE makes no request; a lingering WAIT would
    check("rstw_idle_req", mem_req, 1'b0);
    check("rstw_idle_stall", StallM, 1'b0);

    // Random instruction mix
    for (int i = 0; i < 300; i++) begin
      int          kind = $urandom_range(0, 2);
      bit [31:0]   a    = $urandom_range(0, 32'hFFFF);
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      t = mk(($urandom_range(0, 9) != 0), 1'($urandom), (kind == 1), (kind == 2),
             3'($urandom), 5'($urandom), (kind == 0) ? $urandom : a, $urandom,
             $urandom_range(0, 3), $urandom);
      run(t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so a stuck run still ends
  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
